// File: rtl/board_video_pkg.sv
// Shared types and colours for the NxN board renderer.
// Cell encoding, palette and a cell-index helper.
package board_video_pkg;

  typedef enum logic [1:0] {
    EMPTY  = 2'b00,
    MARK_X = 2'b01,
    MARK_O = 2'b10
  } cell_t;

  localparam logic [23:0] C_CURSOR = 24'hFFFFFF;
  localparam logic [23:0] C_GRID   = 24'h0000FF;
  localparam logic [23:0] C_WIN    = 24'hFFFF00;
  localparam logic [23:0] C_X      = 24'hFF0000;
  localparam logic [23:0] C_O      = 24'h00FF00;
  localparam logic [23:0] C_BG     = 24'h000000;

  function automatic logic [6:0] cell_index(
    input logic [3:0] row,
    input logic [3:0] col,
    input int         n
  );
    return 7'(int'(row) * n + int'(col));
  endfunction

endpackage

// File: rtl/board_cell_locator.sv
// Maps a pixel to its board cell, in-cell offset and gap flag.
// Pure combinational; outputs are zero outside the board extent.
module board_cell_locator #(
  parameter int GRID_N      = 3,
  parameter int CELL_SIZE   = 40,
  parameter int SPACING     = 10,
  parameter int LEFT_OFFSET = 230,
  parameter int TOP_OFFSET  = 150
) (
  input  logic [9:0] x,
  input  logic [9:0] y,
  output logic [3:0] col,
  output logic [3:0] row,
  output logic [9:0] dx,
  output logic [9:0] dy,
  output logic       in_cell,
  output logic       on_line
);

  localparam int P = CELL_SIZE + SPACING;
  localparam int W = GRID_N * P - SPACING;

  logic [10:0] xr;
  logic [10:0] yr;
  logic        x_in;
  logic        y_in;
  logic        cx;
  logic        cy;

  // locate pixel relative to the board origin and cell pitch
  always_comb begin
    col     = '0;
    row     = '0;
    dx      = '0;
    dy      = '0;
    in_cell = 1'b0;
    on_line = 1'b0;
    xr   = {1'b0, x} - 11'(LEFT_OFFSET);
    yr   = {1'b0, y} - 11'(TOP_OFFSET);
    x_in = (x >= 10'(LEFT_OFFSET)) && (xr < 11'(W));
    y_in = (y >= 10'(TOP_OFFSET)) && (yr < 11'(W));
    if (x_in && y_in) begin
      col = 4'(xr / 11'(P));
      row = 4'(yr / 11'(P));
      dx  = 10'(xr % 11'(P));
      dy  = 10'(yr % 11'(P));
    end
    cx      = dx < 10'(CELL_SIZE);
    cy      = dy < 10'(CELL_SIZE);
    in_cell = x_in && y_in && cx && cy;
    on_line = x_in && y_in && !(cx && cy);
  end

endmodule

// File: rtl/board_video_gen.sv
// NxN board renderer: grid, X/O marks, cursor, blinking win cells.
// Two-stage pipeline, board state snapshotted once per frame.
module board_video_gen
  import board_video_pkg::*;
#(
  parameter int GRID_N       = 3,
  parameter int CELL_SIZE    = 40,
  parameter int SPACING      = 10,
  parameter int LEFT_OFFSET  = 230,
  parameter int TOP_OFFSET   = 150,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [9:0]                        x,
  input  logic [9:0]                        y,
  input  logic                              frame_start,
  input  logic [2*GRID_N*GRID_N-1:0]        cells,
  input  logic [GRID_N*GRID_N-1:0]          win_mask,
  input  logic [$clog2(GRID_N*GRID_N)-1:0]  cursor_idx,
  input  logic                              cursor_en,
  output logic [7:0]                        r,
  output logic [7:0]                        g,
  output logic [7:0]                        b
);

  localparam int NC = GRID_N * GRID_N;
  localparam int IW = $clog2(NC);
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  localparam int SW = $clog2(CELL_SIZE) + 3;
  localparam int QW = 2 * SW + 1;

  localparam logic signed [QW-1:0] CM1  = QW'(CELL_SIZE - 1);
  localparam logic signed [QW-1:0] ONE  = QW'(1);
  localparam logic signed [QW-1:0] MONE = QW'(-1);
  localparam logic signed [QW-1:0] RMIN = QW'((CELL_SIZE - 8) * (CELL_SIZE - 8));
  localparam logic signed [QW-1:0] RMAX = QW'((CELL_SIZE - 2) * (CELL_SIZE - 2));

  logic [2*NC-1:0] cells_s;
  logic [NC-1:0]   win_s;
  logic [IW-1:0]   cur_idx_s;
  logic            cur_en_s;
  logic [BW-1:0]   blink_cnt;
  logic            blink_ph;

  logic [3:0] col;
  logic [3:0] row;
  logic [9:0] dx;
  logic [9:0] dy;
  logic       in_cell;
  logic       on_line;
  logic [6:0] idx;
  logic [1:0] mark;
  logic       win_bit;
  logic       cur_sel;

  logic [9:0] dx_q;
  logic [9:0] dy_q;
  logic       in_q;
  logic       line_q;
  logic [1:0] mark_q;
  logic       win_q;
  logic       cur_q;
  logic       ph_q;

  logic signed [QW-1:0] dxs;
  logic signed [QW-1:0] dys;
  logic signed [QW-1:0] u;
  logic signed [QW-1:0] v;
  logic signed [QW-1:0] r2;
  logic signed [QW-1:0] d1;
  logic signed [QW-1:0] d2;
  logic                 hit_x;
  logic                 hit_o;
  logic                 edge_px;
  logic [23:0]          colour;

  board_cell_locator #(
    .GRID_N      (GRID_N),
    .CELL_SIZE   (CELL_SIZE),
    .SPACING     (SPACING),
    .LEFT_OFFSET (LEFT_OFFSET),
    .TOP_OFFSET  (TOP_OFFSET)
  ) u_loc (
    .x       (x),
    .y       (y),
    .col     (col),
    .row     (row),
    .dx      (dx),
    .dy      (dy),
    .in_cell (in_cell),
    .on_line (on_line)
  );

  // latch board inputs and advance blink once per frame
  always_ff @(posedge clk) begin
    if (rst) begin
      cells_s   <= '0;
      win_s     <= '0;
      cur_idx_s <= '0;
      cur_en_s  <= 1'b0;
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
    end else if (frame_start) begin
      cells_s   <= cells;
      win_s     <= win_mask;
      cur_idx_s <= cursor_idx;
      cur_en_s  <= cursor_en;
      if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt <= '0;
        blink_ph  <= ~blink_ph;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  // look up the snapshot for the cell under the incoming pixel
  always_comb begin
    idx     = cell_index(row, col, GRID_N);
    mark    = 2'b00;
    win_bit = 1'b0;
    for (int i = 0; i < NC; i++) begin
      if (idx == 7'(i)) begin
        mark    = cells_s[2*i +: 2];
        win_bit = win_s[i];
      end
    end
    cur_sel = cur_en_s && in_cell && (7'(cur_idx_s) == idx);
  end

  // stage 1: geometry plus the pre-update board state for this pixel
  always_ff @(posedge clk) begin
    if (rst) begin
      dx_q   <= '0;
      dy_q   <= '0;
      in_q   <= 1'b0;
      line_q <= 1'b0;
      mark_q <= 2'b00;
      win_q  <= 1'b0;
      cur_q  <= 1'b0;
      ph_q   <= 1'b0;
    end else begin
      dx_q   <= dx;
      dy_q   <= dy;
      in_q   <= in_cell;
      line_q <= on_line;
      mark_q <= mark;
      win_q  <= win_bit;
      cur_q  <= cur_sel;
      ph_q   <= blink_ph;
    end
  end

  // shape tests and colour priority
  always_comb begin
    dxs     = signed'(QW'(dx_q));
    dys     = signed'(QW'(dy_q));
    u       = (dxs <<< 1) - CM1;
    v       = (dys <<< 1) - CM1;
    r2      = u * u + v * v;
    d1      = dxs - dys;
    d2      = dxs + dys - CM1;
    hit_x   = in_q && (mark_q == MARK_X) &&
              (((d1 >= MONE) && (d1 <= ONE)) ||
               ((d2 >= MONE) && (d2 <= ONE)));
    hit_o   = in_q && (mark_q == MARK_O) &&
              (r2 >= RMIN) && (r2 <= RMAX);
    edge_px = (dx_q < 10'd2) || (dx_q > 10'(CELL_SIZE - 3)) ||
              (dy_q < 10'd2) || (dy_q > 10'(CELL_SIZE - 3));
    colour  = C_BG;
    if (cur_q && edge_px)
      colour = C_CURSOR;
    else if (line_q)
      colour = C_GRID;
    else if ((hit_x || hit_o) && win_q && ph_q)
      colour = C_WIN;
    else if (hit_x)
      colour = C_X;
    else if (hit_o)
      colour = C_O;
  end

  // stage 2: register final colour
  always_ff @(posedge clk) begin
    if (rst) begin
      r <= '0;
      g <= '0;
      b <= '0;
    end else begin
      r <= colour[23:16];
      g <= colour[15:8];
      b <= colour[7:0];
    end
  end

endmodule

// File: tb/tb_board_video_gen.sv
// Directed bench for board_video_gen.
// Expected colours hand-derived from the board geometry.
module tb_board_video_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        frame_start;
  logic [17:0] cells;
  logic [8:0]  win_mask;
  logic [3:0]  cursor_idx;
  logic        cursor_en;
  logic [7:0]  r;
  logic [7:0]  g;
  logic [7:0]  b;

  int errors = 0;
  int checks = 0;

  localparam logic [23:0] BLK = 24'h000000;
  localparam logic [23:0] BLU = 24'h0000FF;
  localparam logic [23:0] RED = 24'hFF0000;
  localparam logic [23:0] GRN = 24'h00FF00;
  localparam logic [23:0] YEL = 24'hFFFF00;
  localparam logic [23:0] WHT = 24'hFFFFFF;

  board_video_gen #(
    .BLINK_FRAMES (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .x           (x),
    .y           (y),
    .frame_start (frame_start),
    .cells       (cells),
    .win_mask    (win_mask),
    .cursor_idx  (cursor_idx),
    .cursor_en   (cursor_en),
    .r           (r),
    .g           (g),
    .b           (b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [23:0] got,
                     input logic [23:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %06h want %06h", tag, got, exp);
    end
  endtask

  task automatic pix(input int xv, input int yv,
                     input logic [23:0] exp, input string tag);
    @(negedge clk);
    x = 10'(xv);
    y = 10'(yv);
    @(posedge clk);
    @(posedge clk);
    #1 chk(tag, {r, g, b}, exp);
  endtask

  task automatic frame();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    x           = 10'd275;
    y           = 10'd200;
    frame_start = 1'b0;
    cells       = '0;
    win_mask    = '0;
    cursor_idx  = '0;
    cursor_en   = 1'b0;

    repeat (3) @(posedge clk);
    #1 chk("rst", {r, g, b}, BLK);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 chk("lat1", {r, g, b}, BLK);
    @(posedge clk);
    #1 chk("lat2", {r, g, b}, BLU);

    pix(275, 200, BLU, "grid");
    pix(275, 305, BLK, "below");
    pix(229, 160, BLK, "left");

    cells[1:0] = 2'b01;
    pix(230, 150, BLK, "x_nofs");
    frame();
    pix(230, 150, RED, "x_corner");
    pix(249, 150, BLK, "x_off");
    pix(249, 169, RED, "x_mid");

    cells[3:2] = 2'b10;
    pix(282, 169, BLK, "o_nofs");
    frame();
    pix(282, 169, GRN, "o_ring");
    pix(299, 169, BLK, "o_ctr");

    cursor_en  = 1'b1;
    cursor_idx = 4'd4;
    frame();
    pix(280, 200, WHT, "cur_tl");
    pix(318, 220, WHT, "cur_rt");
    pix(317, 220, BLK, "cur_in");
    pix(300, 220, BLK, "cur_mid");
    cursor_idx = 4'd9;
    frame();
    pix(280, 200, BLK, "cur_oob");
    pix(272, 200, BLU, "cur_gap");

    do_reset();
    pix(230, 150, BLK, "mrst");
    frame();
    pix(230, 150, RED, "mrst_rec");

    do_reset();
    cells     = 18'b01;
    win_mask  = 9'b001;
    cursor_en = 1'b0;
    @(negedge clk);
    x = 10'd230;
    y = 10'd150;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    @(posedge clk);
    #1 chk("same_clk", {r, g, b}, BLK);
    @(posedge clk);
    #1 chk("ph0b", {r, g, b}, RED);
    frame();
    pix(230, 150, YEL, "ph1a");
    pix(249, 169, YEL, "ph1mid");
    frame();
    pix(230, 150, YEL, "ph1b");
    frame();
    pix(230, 150, RED, "ph0c");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
